// File: rtl/knn_topk_if.sv
// Sample/result bundle between the KNN distance core, the top-K selector and its consumer.
// The master side feeds samples and reads the vote result; the selector is the slave.
interface knn_topk_if #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K       = 4
);
    logic                       start;
    logic                       dist_valid;
    logic                       dist_last;
    logic [DATA_W-1:0]          distance;
    logic [LABEL_W-1:0]         label;
    logic                       ready;
    logic                       result_valid;
    logic [LABEL_W-1:0]         result_label;
    logic [$clog2(K+1)-1:0]     nbr_count;
    logic [DATA_W-1:0]          min_dist;

    modport master (
        output start, dist_valid, dist_last, distance, label,
        input  ready, result_valid, result_label, nbr_count, min_dist
    );

    modport slave (
        input  start, dist_valid, dist_last, distance, label,
        output ready, result_valid, result_label, nbr_count, min_dist
    );
endinterface

// File: rtl/knn_topk.sv
// Streaming top-K selector: keeps the K nearest (distance, label) pairs of a query in sorted
// order, then runs a K-cycle majority vote over the retained labels.
module knn_topk #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K       = 4
) (
    input logic        clk,
    input logic        rst,
    knn_topk_if.slave  bus
);
    localparam int CW = $clog2(K + 1);
    localparam int IW = $clog2(K);

    typedef enum logic [1:0] {IDLE, COLLECT, VOTE, DONE} state_t;

    state_t             state;
    state_t             state_next;

    logic [DATA_W-1:0]  dist_q  [K];
    logic [LABEL_W-1:0] label_q [K];
    logic [K-1:0]       vld_q;
    logic [CW-1:0]      count_q;
    logic [IW-1:0]      vote_idx;
    logic [CW-1:0]      best_cnt;
    logic [LABEL_W-1:0] best_label;

    logic [CW-1:0]      ins_pos;
    logic               insert_ok;
    logic [CW-1:0]      vote_cnt;

    // Equal distances count as "ahead", so an earlier sample keeps its place on ties.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if (vld_q[i] && (dist_q[i] <= bus.distance)) begin
                ins_pos = ins_pos + CW'(1);
            end
        end
        insert_ok = (ins_pos < CW'(K));
    end

    always_comb begin
        vote_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (vld_q[i] && (label_q[i] == label_q[vote_idx])) begin
                vote_cnt = vote_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.start) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (bus.dist_valid && bus.dist_last) state_next = VOTE;
                VOTE:    if (vote_idx == IW'(K - 1)) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= '1;
                label_q[i] <= '0;
            end
            vld_q      <= '0;
            count_q    <= '0;
            vote_idx   <= '0;
            best_cnt   <= '0;
            best_label <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.dist_valid && insert_ok) begin
                        for (int i = 1; i < K; i++) begin
                            if (CW'(i) > ins_pos) begin
                                dist_q[i]  <= dist_q[i-1];
                                label_q[i] <= label_q[i-1];
                                vld_q[i]   <= vld_q[i-1];
                            end
                        end
                        for (int i = 0; i < K; i++) begin
                            if (CW'(i) == ins_pos) begin
                                dist_q[i]  <= bus.distance;
                                label_q[i] <= bus.label;
                                vld_q[i]   <= 1'b1;
                            end
                        end
                        if (count_q != CW'(K)) begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                VOTE: begin
                    // Strict compare: on equal counts the nearer entry's label wins.
                    if (vld_q[vote_idx] && (vote_cnt > best_cnt)) begin
                        best_cnt   <= vote_cnt;
                        best_label <= label_q[vote_idx];
                    end
                    vote_idx <= vote_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ready        = (state == COLLECT);
    assign bus.result_valid = (state == DONE);
    assign bus.result_label = best_label;
    assign bus.nbr_count    = count_q;
    assign bus.min_dist     = dist_q[0];

endmodule

// File: tb/tb_knn_topk.sv
// Self-checking bench for knn_topk: expected vote results are queued as each query is driven
// and popped when the selector raises result_valid.
module tb_knn_topk;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 8;
    localparam int K       = 4;

    typedef struct {
        logic [LABEL_W-1:0] lbl;
        logic [31:0]        cnt;
        logic [DATA_W-1:0]  mind;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];

    knn_topk_if #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K)) bus ();

    knn_topk #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l, input logic last);
        bus.dist_valid = 1'b1;
        bus.dist_last  = last;
        bus.distance   = d;
        bus.label      = l;
        nextCycle();
        bus.dist_valid = 1'b0;
        bus.dist_last  = 1'b0;
    endtask

    task automatic startQuery();
        bus.start = 1'b1;
        nextCycle();
        bus.start = 1'b0;
    endtask

    // n0 = cycles already elapsed since the last sample's clock edge.
    task automatic waitResult(input int n0);
        int   n;
        exp_t e;
        n = n0;
        checkOutput("ready_after_last", 32'(bus.ready), 32'd0);
        while (!bus.result_valid && n < 50) begin
            nextCycle();
            n++;
        end
        checkOutput("result_valid", 32'(bus.result_valid), 32'd1);
        checkOutput("latency", n, K + 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("result_label", 32'(bus.result_label), 32'(e.lbl));
            checkOutput("nbr_count", 32'(bus.nbr_count), e.cnt);
            checkOutput("min_dist", bus.min_dist, e.mind);
        end else begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.dist_valid = 1'b0;
        bus.dist_last  = 1'b0;
        bus.distance   = '0;
        bus.label      = '0;

        repeat (2) nextCycle();
        checkOutput("rst_ready", 32'(bus.ready), 32'd0);
        checkOutput("rst_result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("rst_result_label", 32'(bus.result_label), 32'd0);
        checkOutput("rst_nbr_count", 32'(bus.nbr_count), 32'd0);
        checkOutput("rst_min_dist", bus.min_dist, 32'hFFFF_FFFF);
        rst = 1'b0;
        nextCycle();

        // Samples in IDLE are ignored
        applyStimulus(32'd3, 8'd1, 1'b1);
        checkOutput("idle_nbr_count", 32'(bus.nbr_count), 32'd0);
        checkOutput("idle_ready", 32'(bus.ready), 32'd0);

        // Basic query
        startQuery();
        checkOutput("start_ready", 32'(bus.ready), 32'd1);
        applyStimulus(32'd50, 8'd1, 1'b0);
        applyStimulus(32'd10, 8'd2, 1'b0);
        checkOutput("mid_min_dist", bus.min_dist, 32'd10);
        applyStimulus(32'd30, 8'd3, 1'b0);
        applyStimulus(32'd20, 8'd2, 1'b0);
        exp_q.push_back('{lbl: 8'd2, cnt: 32'd4, mind: 32'd10});
        applyStimulus(32'd40, 8'd1, 1'b1);
        waitResult(1);
        applyStimulus(32'd0, 8'd9, 1'b1);
        checkOutput("done_ignore_count", 32'(bus.nbr_count), 32'd4);
        checkOutput("done_ignore_min", bus.min_dist, 32'd10);
        checkOutput("done_hold_valid", 32'(bus.result_valid), 32'd1);

        // Tie vote resolves to nearest label
        startQuery();
        checkOutput("start_clears_valid", 32'(bus.result_valid), 32'd0);
        applyStimulus(32'd5, 8'd7, 1'b0);
        applyStimulus(32'd5, 8'd9, 1'b0);
        applyStimulus(32'd5, 8'd9, 1'b0);
        exp_q.push_back('{lbl: 8'd7, cnt: 32'd4, mind: 32'd5});
        applyStimulus(32'd5, 8'd7, 1'b1);
        waitResult(1);

        // Partial list, with a stray sample driven during VOTE
        startQuery();
        applyStimulus(32'd100, 8'd3, 1'b0);
        exp_q.push_back('{lbl: 8'd3, cnt: 32'd2, mind: 32'd100});
        applyStimulus(32'd200, 8'd4, 1'b1);
        bus.dist_valid = 1'b1;
        bus.distance   = 32'd0;
        bus.label      = 8'd9;
        nextCycle();
        bus.dist_valid = 1'b0;
        waitResult(2);

        // Discard when full
        startQuery();
        for (int i = 1; i <= 4; i++) applyStimulus(32'(i), 8'(i), 1'b0);
        applyStimulus(32'd4, 8'd5, 1'b0);
        checkOutput("full_discard_count", 32'(bus.nbr_count), 32'd4);
        exp_q.push_back('{lbl: 8'd1, cnt: 32'd4, mind: 32'd1});
        applyStimulus(32'hFFFF_FFFF, 8'd6, 1'b1);
        waitResult(1);

        startQuery();
        exp_q.push_back('{lbl: 8'd5, cnt: 32'd1, mind: 32'd0});
        applyStimulus(32'd0, 8'd5, 1'b1);
        waitResult(1);

        // start together with a sample: sample dropped
        bus.start      = 1'b1;
        bus.dist_valid = 1'b1;
        bus.distance   = 32'd3;
        bus.label      = 8'd2;
        nextCycle();
        bus.start      = 1'b0;
        bus.dist_valid = 1'b0;
        checkOutput("abort_nbr_count", 32'(bus.nbr_count), 32'd0);
        checkOutput("abort_min_dist", bus.min_dist, 32'hFFFF_FFFF);
        checkOutput("abort_ready", 32'(bus.ready), 32'd1);

        // Reset during VOTE
        applyStimulus(32'd7, 8'd1, 1'b1);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("vote_rst_ready", 32'(bus.ready), 32'd0);
        checkOutput("vote_rst_nbr_count", 32'(bus.nbr_count), 32'd0);
        checkOutput("vote_rst_min_dist", bus.min_dist, 32'hFFFF_FFFF);
        repeat (K + 2) nextCycle();
        checkOutput("vote_rst_result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("vote_rst_label", 32'(bus.result_label), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/knn_topk.md
# knn_topk

Streaming top-K selector and majority voter placed directly downstream of the KNN distance core. Accepts one (squared distance, class label) pair per cycle and maintains a sorted list of the K smallest distances seen since `start`. On the last sample it runs a K-cycle majority vote over the retained labels and presents the winning label, the number of neighbours retained, and the nearest distance.

## Interface
- DATA_W, 32, width of incoming squared distance
- LABEL_W, 8, width of class label
- K, 4, neighbours retained (2..16)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse: clear list, begin new query
- dist_valid  input  1  distance/label sample present this cycle
- dist_last  input  1  qualifies dist_valid: final sample of query
- distance  input  DATA_W  squared distance from distance core
- label  input  LABEL_W  class label of the training point
- ready  output  1  high while samples are accepted (COLLECT only)
- result_valid  output  1  vote result valid, held until start/rst
- result_label  output  LABEL_W  majority label
- nbr_count  output  $clog2(K+1)  valid entries in list
- min_dist  output  DATA_W  distance of entry 0 (nearest)

## Operation
- Storage: K entries {dist, label, vld}, entry 0 nearest. Cleared state: vld=0, dist=all-ones, label=0.
- States: IDLE, COLLECT, VOTE, DONE.
- IDLE: ready=0; samples ignored. start -> clear list, go COLLECT.
- COLLECT: ready=1. Sample accepted when dist_valid=1.
  - Insert position p = number of valid entries with dist <= new distance (equal distances: earlier sample stays ahead).
  - p < K: entries p..K-2 shift to p+1..K-1, entry K-1 dropped, new sample written at p with vld=1.
  - p = K (list full, new >= worst): sample discarded, list unchanged.
  - dist_valid & dist_last: sample processed as above, then go VOTE.
- VOTE: ready=0, K cycles, index j=0..K-1. Cycle j: cnt_j = number of valid entries whose label equals entry j's label (parallel compare). If entry j valid and cnt_j strictly greater than best count, best := (cnt_j, label_j). Strict comparison => ties resolve to the label of the nearest entry. After j=K-1 go DONE.
- DONE: result_valid=1; result_label, nbr_count, min_dist stable. Samples ignored. start -> clear, COLLECT.
- start has priority in every state: a dist_valid in the same cycle is dropped; result_valid clears next cycle.
- rst mid-COLLECT or mid-VOTE: everything to reset values, state IDLE.
- dist_last without dist_valid is ignored.
- Distances unsigned; comparisons unsigned DATA_W bits; no arithmetic overflow possible.

## Timing
- Reset values: ready=0, result_valid=0, result_label=0, nbr_count=0, min_dist=all-ones, state IDLE, list cleared.
- start at cycle t -> ready=1 at t+1.
- Sample accepted at t -> list, nbr_count, min_dist updated at t+1. Throughput one sample/cycle, no bubbles.
- Last sample at t -> ready=0 at t+1, VOTE cycles t+1..t+K, result_valid=1 from t+K+1.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst 2 cycles -> ready=0, result_valid=0, result_label=0, nbr_count=0, min_dist=0xFFFFFFFF.
- Basic, K=4: start; distances 50,10,30,20,40 labels 1,2,3,2,1, last on 40 -> list 10/2,20/2,30/3,40/1; result_label=2, nbr_count=4, min_dist=10, result_valid exactly 5 cycles after last sample.
- Tie vote: distances 5,5,5,5 labels 7,9,9,7 -> list order 7,9,9,7; counts 2/2 -> result_label=7.
- Partial list: samples 100/L3, 200/L4 (last) -> nbr_count=2, result_label=3, min_dist=100.
- Discard at full: distances 1,2,3,4 then 4 and 0xFFFFFFFF (last) -> list unchanged 1,2,3,4; then a 0 sample in a new query after start -> min_dist=0.
- Abort: start together with dist_valid (distance 3) -> sample dropped, nbr_count=0; rst during VOTE -> IDLE, result_valid stays 0; ready=0 and samples ignored in IDLE/VOTE/DONE.
